// File: rtl/memory_read.sv
// memory_read: streams image, conv-weight or dense-weight RAM contents onto a valid/ready port.
// Reads are issued only when the output FIFO can absorb every read still in flight.
module memory_read #(
    parameter int RD_LAT      = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int IMG_DEPTH   = 225,
    parameter int CONV_DEPTH  = 18816,
    parameter int DENSE_DEPTH = 16746
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  region,
    input  logic [14:0] base_addr,
    input  logic [14:0] length,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  image_ram_addr,
    input  logic [7:0]  q0,
    input  logic [7:0]  q1,
    input  logic [7:0]  q2,
    input  logic [7:0]  q3,
    output logic [14:0] conv_ram_addr,
    input  logic [7:0]  q_conv,
    output logic [14:0] dense_ram_addr,
    input  logic [7:0]  q_dense,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] REG_IMG   = 2'd0;
    localparam logic [1:0] REG_CONV  = 2'd1;
    localparam logic [1:0] REG_BAD   = 2'd3;

    // Output stream: a word transfers on every rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_data/out_last hold while stalled.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       cmd_region;
    logic [14:0]      cmd_base;
    logic [14:0]      cmd_len;
    logic [14:0]      issued;
    logic [14:0]      returned;
    logic [RD_LAT:0]  lat_pipe;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [32:0]      fifo_mem [FIFO_DEPTH];

    logic [15:0] region_depth;
    logic [15:0] cmd_end;
    logic        cmd_legal;
    logic        fifo_room;
    logic        issue;
    logic        push;
    logic        pop;
    logic [14:0] issue_addr;
    logic [31:0] ret_data;
    logic        ret_last;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign region_depth = (cmd_region == REG_IMG)  ? 16'(IMG_DEPTH) :
                          (cmd_region == REG_CONV) ? 16'(CONV_DEPTH) : 16'(DENSE_DEPTH);
    assign cmd_end      = {1'b0, cmd_base} + {1'b0, cmd_len};
    assign cmd_legal    = (cmd_region != REG_BAD) && (cmd_end <= region_depth);

    // Counting in-flight reads as occupied slots is what makes FIFO overflow impossible.
    assign fifo_room  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue      = ((state == S_CHECK) && cmd_legal && (cmd_len != '0)) ||
                        ((state == S_ISSUE) && (issued < cmd_len) && fifo_room);
    assign issue_addr = cmd_base + issued;
    assign push       = lat_pipe[RD_LAT];
    assign pop        = out_valid && out_ready;

    always_comb begin
        ret_data = {24'd0, q_dense};
        case (cmd_region)
            REG_IMG:  ret_data = {q0, q1, q2, q3};
            REG_CONV: ret_data = {24'd0, q_conv};
            default:  ret_data = {24'd0, q_dense};
        endcase
    end
    assign ret_last = (returned == cmd_len - 15'd1);

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr][31:0] : 32'd0;
    assign out_last  = out_valid && fifo_mem[rd_ptr][32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_pipe <= '0;
            inflight <= '0;
        end else begin
            lat_pipe <= {lat_pipe[RD_LAT-1:0], issue};
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {ret_last, ret_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            cmd_region     <= '0;
            cmd_base       <= '0;
            cmd_len        <= '0;
            issued         <= '0;
            returned       <= '0;
            image_ram_addr <= '0;
            conv_ram_addr  <= '0;
            dense_ram_addr <= '0;
        end else begin
            if (issue) begin
                issued <= issued + 15'd1;
                case (cmd_region)
                    REG_IMG:  image_ram_addr <= issue_addr[9:0];
                    REG_CONV: conv_ram_addr  <= issue_addr;
                    default:  dense_ram_addr <= issue_addr;
                endcase
            end
            if (push) returned <= returned + 15'd1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cmd_region <= region;
                        cmd_base   <= base_addr;
                        cmd_len    <= length;
                        issued     <= '0;
                        returned   <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!cmd_legal || (cmd_len == '0)) begin
                        err   <= !cmd_legal;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issued == cmd_len) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((inflight == '0) && (fifo_count == '0)) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    no_fifo_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_memory_read.sv
// Directed bench for memory_read: one RD_LAT=1 and one RD_LAT=2 instance share the command inputs,
// each backed by a behavioural RAM model whose contents are a known function of the address.
module tb_memory_read;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  region = '0;
    logic [14:0] base_addr = '0;
    logic [14:0] length = '0;
    logic        out_ready = 1'b1;

    logic        busy1, done1, err1, ov1, ol1;
    logic [31:0] od1;
    logic [9:0]  ia1;
    logic [14:0] ca1, da1;
    logic [7:0]  q0_1, q1_1, q2_1, q3_1, qc1, qd1;

    logic        busy2, done2, err2, ov2, ol2;
    logic [31:0] od2;
    logic [9:0]  ia2, ia2_d;
    logic [14:0] ca2, da2, ca2_d, da2_d;
    logic [7:0]  q0_2, q1_2, q2_2, q3_2, qc2, qd2;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got1_q[$];
    logic [31:0] got2_q[$];
    int cyc, first_v1, first_v2, done_c1, done_c2, last_pos1, last_pos2, last_cnt1, last_cnt2;
    int last_acc1, hold_bad1, hold_bad2;
    logic err_d1, busy_at1, err_at1, addr_moved1, timed_out;

    always #5 clk = ~clk;

    memory_read #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .region(region), .base_addr(base_addr),
        .length(length), .busy(busy1), .done(done1), .err(err1), .image_ram_addr(ia1),
        .q0(q0_1), .q1(q1_1), .q2(q2_1), .q3(q3_1), .conv_ram_addr(ca1), .q_conv(qc1),
        .dense_ram_addr(da1), .q_dense(qd1), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_last(ol1)
    );

    memory_read #(.RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .region(region), .base_addr(base_addr),
        .length(length), .busy(busy2), .done(done2), .err(err2), .image_ram_addr(ia2),
        .q0(q0_2), .q1(q1_2), .q2(q2_2), .q3(q3_2), .conv_ram_addr(ca2), .q_conv(qc2),
        .dense_ram_addr(da2), .q_dense(qd2), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_last(ol2)
    );

    function automatic logic [7:0] img_byte(input logic [9:0] a, input int k);
        return 8'(a + 10'(k));
    endfunction

    function automatic logic [7:0] conv_byte(input logic [14:0] a);
        return 8'((a * 15'd3) + 15'd7);
    endfunction

    function automatic logic [7:0] dense_byte(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction

    // Single-cycle RAMs for dut1, two-cycle RAMs for dut2.
    always @(posedge clk) begin
        q0_1 <= img_byte(ia1, 0);
        q1_1 <= img_byte(ia1, 1);
        q2_1 <= img_byte(ia1, 2);
        q3_1 <= img_byte(ia1, 3);
        qc1  <= conv_byte(ca1);
        qd1  <= dense_byte(da1);
        ia2_d <= ia2;
        ca2_d <= ca2;
        da2_d <= da2;
        q0_2 <= img_byte(ia2_d, 0);
        q1_2 <= img_byte(ia2_d, 1);
        q2_2 <= img_byte(ia2_d, 2);
        q3_2 <= img_byte(ia2_d, 3);
        qc2  <= conv_byte(ca2_d);
        qd2  <= dense_byte(da2_d);
    end

    // Issues one command at cycle T=0 and records both streams until both done pulses are seen.
    task automatic run_cmd(input logic [1:0] r, input logic [14:0] b, input logic [14:0] l,
                           input bit toggle, input int max_cyc);
        logic pv1, pr1, pv2, pr2;
        logic [32:0] pd1, pd2;
        logic [9:0] ia0;
        logic [14:0] ca0, da0;
        got1_q.delete();
        got2_q.delete();
        first_v1 = -1; first_v2 = -1; done_c1 = -1; done_c2 = -1;
        last_pos1 = -1; last_pos2 = -1; last_cnt1 = 0; last_cnt2 = 0; last_acc1 = -1;
        hold_bad1 = 0; hold_bad2 = 0; err_d1 = 1'bx; addr_moved1 = 1'b0;
        pv1 = 0; pr1 = 0; pv2 = 0; pr2 = 0; pd1 = '0; pd2 = '0;
        ia0 = ia1; ca0 = ca1; da0 = da1;
        region = r; base_addr = b; length = l; start = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (!((done_c1 >= 0) && (done_c2 >= 0)) && (cyc < max_cyc)) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                busy_at1 = busy1;
                err_at1  = err1;
            end
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if ((ia1 != ia0) || (ca1 != ca0) || (da1 != da0)) addr_moved1 = 1'b1;
            if (pv1 && !pr1 && (!ov1 || ({ol1, od1} != pd1))) hold_bad1++;
            if (ov1 && (first_v1 < 0)) first_v1 = cyc;
            if (ov1 && out_ready) begin
                got1_q.push_back(od1);
                last_acc1 = cyc;
                if (ol1) begin last_cnt1++; last_pos1 = got1_q.size() - 1; end
            end
            if (done1 && (done_c1 < 0)) begin done_c1 = cyc; err_d1 = err1; end
            pv1 = ov1; pr1 = out_ready; pd1 = {ol1, od1};
            if (pv2 && !pr2 && (!ov2 || ({ol2, od2} != pd2))) hold_bad2++;
            if (ov2 && (first_v2 < 0)) first_v2 = cyc;
            if (ov2 && out_ready) begin
                got2_q.push_back(od2);
                if (ol2) begin last_cnt2++; last_pos2 = got2_q.size() - 1; end
            end
            if (done2 && (done_c2 < 0)) done_c2 = cyc;
            pv2 = ov2; pr2 = out_ready; pd2 = {ol2, od2};
        end
        timed_out = !((done_c1 >= 0) && (done_c2 >= 0));
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy1, done1, err1, ov1, ol1} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {busy1, done1, err1, ov1, ol1});
        end
        checks++;
        if (od1 !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", od1); end
        checks++;
        if ({ia1, ca1, da1} !== 40'd0) begin
            errors++; $display("FAIL reset_addr: got %h/%h/%h expected 0", ia1, ca1, da1);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy1, ov1, busy2, ov2} !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 0000", {busy1, ov1, busy2, ov2});
        end
    endtask

    task automatic test_image();
        int k;
        logic [31:0] e;
        for (int i = 0; i < 225; i++) exp_q.push_back({8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)});
        run_cmd(2'd0, 15'd0, 15'd225, 1'b0, 1500);
        checks++;
        if (timed_out) begin errors++; $display("FAIL image_timeout: got no done expected done"); end
        checks++;
        if (busy_at1 !== 1'b1) begin errors++; $display("FAIL image_busy: got %b expected 1", busy_at1); end
        checks++;
        if (got1_q.size() != 225) begin
            errors++; $display("FAIL image_count: got %0d expected 225", got1_q.size());
        end
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ((k >= got1_q.size()) || (got1_q[k] !== e)) begin
                errors++; $display("FAIL image_word%0d: got %h expected %h", k,
                                   (k < got1_q.size()) ? got1_q[k] : 32'hx, e);
            end
            k++;
        end
        checks++;
        if ((last_cnt1 != 1) || (last_pos1 != 224)) begin
            errors++; $display("FAIL image_last: got %0d flags at %0d expected 1 at 224", last_cnt1, last_pos1);
        end
        checks++;
        if (first_v1 != 4) begin errors++; $display("FAIL image_latency: got T+%0d expected T+4", first_v1); end
        checks++;
        if (last_acc1 != first_v1 + 224) begin
            errors++; $display("FAIL image_rate: got last at %0d expected %0d", last_acc1, first_v1 + 224);
        end
        checks++;
        if (err_d1 !== 1'b0) begin errors++; $display("FAIL image_err: got %b expected 0", err_d1); end
    endtask

    task automatic test_conv_backpressure();
        run_cmd(2'd1, 15'd100, 15'd16, 1'b1, 300);
        checks++;
        if (timed_out) begin errors++; $display("FAIL conv_timeout: got no done expected done"); end
        checks++;
        if (got1_q.size() != 16) begin errors++; $display("FAIL conv_count: got %0d expected 16", got1_q.size()); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ((k >= got1_q.size()) || (got1_q[k] !== {24'd0, conv_byte(15'(100 + k))})) begin
                errors++; $display("FAIL conv_word%0d: got %h expected %h", k,
                                   (k < got1_q.size()) ? got1_q[k] : 32'hx, {24'd0, conv_byte(15'(100 + k))});
            end
        end
        checks++;
        if (hold_bad1 != 0) begin errors++; $display("FAIL conv_hold: got %0d unstable stalls expected 0", hold_bad1); end
        checks++;
        if ((last_cnt1 != 1) || (last_pos1 != 15)) begin
            errors++; $display("FAIL conv_last: got %0d flags at %0d expected 1 at 15", last_cnt1, last_pos1);
        end
        checks++;
        if (first_v1 != 4) begin errors++; $display("FAIL conv_latency: got T+%0d expected T+4", first_v1); end
    endtask

    task automatic test_bounds();
        run_cmd(2'd2, 15'd16740, 15'd6, 1'b0, 200);
        checks++;
        if (got1_q.size() != 6) begin errors++; $display("FAIL dense_count: got %0d expected 6", got1_q.size()); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ((k >= got1_q.size()) || (got1_q[k] !== {24'd0, dense_byte(15'(16740 + k))})) begin
                errors++; $display("FAIL dense_word%0d: got %h expected %h", k,
                                   (k < got1_q.size()) ? got1_q[k] : 32'hx, {24'd0, dense_byte(15'(16740 + k))});
            end
        end
        checks++;
        if ((last_pos1 != 5) || (err_d1 !== 1'b0)) begin
            errors++; $display("FAIL dense_end: got last %0d err %b expected last 5 err 0", last_pos1, err_d1);
        end
        run_cmd(2'd2, 15'd16740, 15'd7, 1'b0, 50);
        checks++;
        if ((done_c1 != 2) || (err_d1 !== 1'b1)) begin
            errors++; $display("FAIL oob_done: got done at T+%0d err %b expected T+2 err 1", done_c1, err_d1);
        end
        checks++;
        if (addr_moved1 || (got1_q.size() != 0)) begin
            errors++; $display("FAIL oob_access: got addr_moved %b words %0d expected 0 0", addr_moved1, got1_q.size());
        end
    endtask

    task automatic test_zero_illegal();
        run_cmd(2'd1, 15'd5, 15'd0, 1'b0, 50);
        checks++;
        if ((done_c1 != 2) || (err_d1 !== 1'b0)) begin
            errors++; $display("FAIL zero_done: got done at T+%0d err %b expected T+2 err 0", done_c1, err_d1);
        end
        checks++;
        if ((first_v1 >= 0) || addr_moved1) begin
            errors++; $display("FAIL zero_quiet: got valid at %0d addr_moved %b expected none", first_v1, addr_moved1);
        end
        run_cmd(2'd3, 15'd0, 15'd4, 1'b0, 50);
        checks++;
        if ((done_c1 != 2) || (err_d1 !== 1'b1)) begin
            errors++; $display("FAIL region3_done: got done at T+%0d err %b expected T+2 err 1", done_c1, err_d1);
        end
        checks++;
        if (first_v1 >= 0) begin errors++; $display("FAIL region3_quiet: got valid at T+%0d expected none", first_v1); end
    endtask

    task automatic test_reset_mid_stream();
        int n, guard;
        bit done_seen;
        logic e1;
        got1_q.delete();
        region = 2'd1; base_addr = 15'd200; length = 15'd64; start = 1'b1; out_ready = 1'b1;
        n = 0; guard = 0; done_seen = 0; e1 = 1'bx;
        while ((n < 10) && (guard < 100)) begin
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (guard == 1) e1 = err1;
            if (ov1 && out_ready) begin got1_q.push_back(od1); n++; end
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL midrst_words: got %0d expected 10", n); end
        checks++;
        if (e1 !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", e1); end
        for (int k = 0; k < got1_q.size(); k++) begin
            checks++;
            if (got1_q[k] !== {24'd0, conv_byte(15'(200 + k))}) begin
                errors++; $display("FAIL midrst_word%0d: got %h expected %h", k, got1_q[k], {24'd0, conv_byte(15'(200 + k))});
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy1, done1, err1, ov1, ol1} !== 5'b0 || od1 !== 32'd0) begin
            errors++; $display("FAIL midrst_outputs: got flags %b data %h expected 0", {busy1, done1, err1, ov1, ol1}, od1);
        end
        checks++;
        if ({ia1, ca1, da1} !== 40'd0) begin
            errors++; $display("FAIL midrst_addr: got %h/%h/%h expected 0", ia1, ca1, da1);
        end
        repeat (2) begin @(posedge clk); #1; if (done1) done_seen = 1; end
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #1; if (done1) done_seen = 1; end
        checks++;
        if (done_seen) begin errors++; $display("FAIL midrst_nodone: got done 1 expected 0"); end
        run_cmd(2'd1, 15'd300, 15'd8, 1'b0, 200);
        checks++;
        if ((got1_q.size() != 8) || (last_pos1 != 7)) begin
            errors++; $display("FAIL restart_count: got %0d words last %0d expected 8 last 7", got1_q.size(), last_pos1);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ((k >= got1_q.size()) || (got1_q[k] !== {24'd0, conv_byte(15'(300 + k))})) begin
                errors++; $display("FAIL restart_word%0d: got %h expected %h", k,
                                   (k < got1_q.size()) ? got1_q[k] : 32'hx, {24'd0, conv_byte(15'(300 + k))});
            end
        end
    endtask

    task automatic test_rdlat2();
        run_cmd(2'd1, 15'd100, 15'd16, 1'b1, 300);
        checks++;
        if (timed_out) begin errors++; $display("FAIL lat2_timeout: got no done expected done"); end
        checks++;
        if (got2_q.size() != 16) begin errors++; $display("FAIL lat2_count: got %0d expected 16", got2_q.size()); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ((k >= got2_q.size()) || (got2_q[k] !== {24'd0, conv_byte(15'(100 + k))})) begin
                errors++; $display("FAIL lat2_word%0d: got %h expected %h", k,
                                   (k < got2_q.size()) ? got2_q[k] : 32'hx, {24'd0, conv_byte(15'(100 + k))});
            end
        end
        checks++;
        if (first_v2 != 5) begin errors++; $display("FAIL lat2_latency: got T+%0d expected T+5", first_v2); end
        checks++;
        if ((hold_bad2 != 0) || (last_cnt2 != 1) || (last_pos2 != 15)) begin
            errors++; $display("FAIL lat2_stream: got hold %0d last %0d@%0d expected 0 1@15", hold_bad2, last_cnt2, last_pos2);
        end
    endtask

    initial begin
        test_reset();
        test_image();
        test_conv_backpressure();
        test_bounds();
        test_zero_illegal();
        test_reset_mid_stream();
        test_rdlat2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "time limit");
    end
endmodule
